// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with a valid/ready intake.
// One word of NBITS bits is latched on accept. It is then shifted out one bit per
// shift_en strobe, in the bit order that was selected at accept time.
// Optional feature macro: PISO_PARITY_EN. When it is defined, an even-parity bit
// is sent after the last data bit of every word.
module piso_serializer #(
  parameter int unsigned NBITS      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned   CW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  // Bit currently at the output end of the shift register for the latched order.
  function automatic logic head_bit(input logic [NBITS-1:0] w, input logic msb);
    return msb ? w[NBITS-1] : w[0];
  endfunction

  // Move the next bit into the output position. The vacated end is filled with zero.
  function automatic logic [NBITS-1:0] advance(input logic [NBITS-1:0] w, input logic msb);
    return msb ? {w[NBITS-2:0], 1'b0} : {1'b0, w[NBITS-1:1]};
  endfunction

  state_t            state_q, state_d;
  logic [NBITS-1:0]  shreg_q, shreg_d;
  logic              msb_q,   msb_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
`ifdef PISO_PARITY_EN
  logic              par_q,   par_d;
`endif
  logic              sout_q,  sout_d;
  logic              sv_q,    sv_d;
  logic              last_q,  last_d;
  logic              busy_q,  busy_d;
  logic              accept;
  logic              load;

  // The intake is open when the block is idle. It is also open on the final bit's
  // strobe, so that a back-to-back word can follow without a gap.
  assign in_ready = (state_q == IDLE) || (last_q && shift_en);
  assign accept   = in_valid && in_ready;

  // Next-state logic, followed by the registered output values for that next state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // shift_en has no effect here. An accepted word shows its first bit next cycle.
        load = accept;
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q != LAST_IDX) begin
            shreg_d = advance(shreg_q, msb_q);
            cnt_d   = cnt_q + CW'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = SHIFT;
      shreg_d = in_data;
      msb_d   = msb_first;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^in_data;
`endif
    end

    sout_d = IDLE_LEVEL;
    sv_d   = 1'b0;
    last_d = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      SHIFT: begin
        sout_d = head_bit(shreg_d, msb_d);
        sv_d   = 1'b1;
        busy_d = 1'b1;
`ifdef PISO_PARITY_EN
        last_d = 1'b0;
`else
        last_d = (cnt_d == LAST_IDX);
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_d = par_d;
        sv_d   = 1'b1;
        last_d = 1'b1;
        busy_d = 1'b1;
      end
`endif
      default: begin
        sout_d = IDLE_LEVEL;
      end
    endcase
  end

  // State and output registers. clr aborts any word and takes priority over everything else.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
      sout_q  <= IDLE_LEVEL;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      msb_q   <= msb_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign last       = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (NBITS = 8, IDLE_LEVEL = 1).
// Each record describes one clock cycle. It holds the inputs driven during that
// cycle, the in_ready value expected during that cycle, and the registered
// outputs expected after the clock edge.
module tb_piso_serializer;
  localparam int   NB = 8;
  localparam logic IL = 1'b1;

  logic          clk = 1'b0;
  logic          clr, in_valid, in_ready, msb_first, shift_en;
  logic          sout, sout_valid, last, busy;
  logic [NB-1:0] in_data;

  always #5 clk = ~clk;

  piso_serializer #(.NBITS(NB), .IDLE_LEVEL(IL)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .shift_en  (shift_en),
    .sout      (sout),
    .sout_valid(sout_valid),
    .last      (last),
    .busy      (busy)
  );

  typedef struct {
    logic       c;   // clr
    logic       v;   // in_valid
    logic [7:0] d;   // in_data
    logic       m;   // msb_first
    logic       s;   // shift_en
    logic       cr;  // compare in_ready this cycle
    logic       r;   // expected in_ready
    logic       so;  // expected sout after edge
    logic       sv;  // expected sout_valid
    logic       l;   // expected last
    logic       b;   // expected busy
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // Hand-derived serial bit sequences, written in transmission order.
  logic [0:7] s_a5_msb, s_a5_lsb, s_01_msb, s_80_msb, s_01_lsb, s_07_lsb, s_03_lsb;

  task automatic add(input logic c, input logic v, input logic [7:0] d, input logic m,
                     input logic s, input logic cr, input logic r, input logic so,
                     input logic sv, input logic l, input logic b);
    vec_t t;
    t.c = c; t.v = v; t.d = d; t.m = m; t.s = s;
    t.cr = cr; t.r = r; t.so = so; t.sv = sv; t.l = l; t.b = b;
    tbl.push_back(t);
  endtask

  initial begin
    s_a5_msb = 8'b1010_0101;
    s_a5_lsb = 8'b1010_0101;
    s_01_msb = 8'b0000_0001;
    s_80_msb = 8'b1000_0000;
    s_01_lsb = 8'b1000_0000;
    s_07_lsb = 8'b1110_0000;
    s_03_lsb = 8'b1100_0000;

    // Reset, then shift_en while idle must do nothing.
    add(1, 0, 8'h00, 0, 0, 0, 0, IL, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);

`ifdef PISO_PARITY_EN
    // 8'h07 sent LSB first, followed by parity 1.
    add(0, 1, 8'h07, 0, 1, 1, 1, s_07_lsb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 0, 8'h00, 0, 1, 1, 0, s_07_lsb[j], 1, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1'b1, 1, 1, 1);
    // The parity bit is held while shift_en is low.
    add(0, 0, 8'h00, 0, 0, 1, 0, 1'b1, 1, 1, 1);
    // 8'h03 accepted back-to-back from the parity bit, followed by parity 0.
    add(0, 1, 8'h03, 0, 1, 1, 1, s_03_lsb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 0, 8'h00, 0, 1, 1, 0, s_03_lsb[j], 1, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1'b0, 1, 1, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);
`else
    // 8'hA5, MSB first, shift_en always high. Accepted together with shift_en in idle.
    add(0, 1, 8'hA5, 1, 1, 1, 1, s_a5_msb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 0, 8'h00, 0, 1, 1, 0, s_a5_msb[j], 1, (j == 7), 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, IL, 0, 0, 0);

    // 8'hA5, LSB first, shift_en every third cycle. While busy, msb_first toggles
    // and in_data changes; neither may affect the bits being sent.
    add(0, 1, 8'hA5, 0, 0, 1, 1, s_a5_lsb[0], 1, 0, 1);
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 2; k++)
        add(0, 0, 8'(j * 37 + k), (k == 0), 0, 1, 0, s_a5_lsb[j], 1, (j == 7), 1);
      if (j < 7)
        add(0, 0, 8'hFF, j[0], 1, 1, 0, s_a5_lsb[j + 1], 1, (j + 1 == 7), 1);
      else
        add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);
    end

    // in_valid held high: 8'h01, then 8'h80 accepted on the last-bit strobe.
    add(0, 1, 8'h01, 1, 1, 1, 1, s_01_msb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 1, 8'h80, 0, 1, 1, 0, s_01_msb[j], 1, (j == 7), 1);
    add(0, 1, 8'h80, 1, 1, 1, 1, s_80_msb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 0, 8'h00, 0, 1, 1, 0, s_80_msb[j], 1, (j == 7), 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);

    // 8'hFF aborted by clr after bit 3. clr overrides a simultaneous in_valid and
    // shift_en. A fresh 8'h01 (LSB first) must then restart from bit 0.
    add(0, 1, 8'hFF, 1, 1, 1, 1, 1'b1, 1, 0, 1);
    for (int j = 1; j < 4; j++) add(0, 0, 8'h00, 0, 1, 1, 0, 1'b1, 1, 0, 1);
    add(1, 1, 8'h01, 0, 1, 1, 0, IL, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, IL, 0, 0, 0);
    add(0, 1, 8'h01, 0, 1, 1, 1, s_01_lsb[0], 1, 0, 1);
    for (int j = 1; j < 8; j++) add(0, 0, 8'h00, 0, 1, 1, 0, s_01_lsb[j], 1, (j == 7), 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, IL, 0, 0, 0);
`endif

    clr = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0; shift_en = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      clr       = tbl[i].c;
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      msb_first = tbl[i].m;
      shift_en  = tbl[i].s;
      #3;
      if (tbl[i].cr && (in_ready !== tbl[i].r)) begin
        nerr++;
        $display("FAIL in_ready vec %0d: got %b want %b", i, in_ready, tbl[i].r);
      end
      @(posedge clk);
      #1;
      nvec++;
      if ({sout, sout_valid, last, busy} !== {tbl[i].so, tbl[i].sv, tbl[i].l, tbl[i].b}) begin
        nerr++;
        $display("FAIL outputs vec %0d: got sout/vld/last/busy=%b%b%b%b want %b%b%b%b",
                 i, sout, sout_valid, last, busy, tbl[i].so, tbl[i].sv, tbl[i].l, tbl[i].b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
